lab5_mcore_mem_arbiter: RTL and testbench

Shares one memory request/response port pair among NREQ requesters, such as per-core imem and dmem ports in the multicore build. Requests use val/rdy handshakes and the (8,32,32) request and (8,32) response message formats. A round-robin arbiter with grant hold chooses the requester. The requester id is written into the opaque field, and responses are routed back by that id. A per-requester outstanding-request limit provides backpressure.

---
 rtl/lab5_mcore_mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_lab5_mcore_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lab5_mcore_mem_arbiter.sv
// ---------------------------------------------------------------------------
// lab5_mcore_mem_arbiter
//   Shares one memory request/response port pair among NREQ requesters.
//   Requests are picked by a round-robin arbiter. Once a request is offered
//   to memory, the grant is held until memory accepts it. The requester id
//   rides in the top IDW bits of the opaque field, and responses are routed
//   back by that id. A per-requester outstanding-request limit (MAX_OUTST)
//   provides backpressure. err is a sticky flag for protocol errors.
//
//   Ports
//     clk, reset          clock, asynchronous active-low reset
//     req_msg/val/rdy     NREQ request ports, 77-bit msgs, slot i at [77i+:77]
//     resp_msg/val/rdy    NREQ response ports, 45-bit msgs, slot i at [45i+:45]
//     memreq_msg/val/rdy  shared memory request port
//     memresp_msg/val/rdy shared memory response port
//     err                 sticky protocol-error flag
//
//   Optional build macro LAB5_MCORE_ARB_STATS_EN adds:
//     grant_cnt  NREQ*16  per-requester request-fire counters (wrapping)
//     stall_cnt  32       cycles with memreq_val=1 and memreq_rdy=0 (wrapping)
// ---------------------------------------------------------------------------

// Per-requester slice: outstanding counter (and grant counter in stats builds).
module lab5_mcore_arb_lane #(
    parameter int MAX_OUTST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,       // request fire for this requester
    input  logic        dec,       // response fire for this requester
    output logic        room,      // below the outstanding limit
    output logic        undf       // response fire with nothing outstanding
`ifdef LAB5_MCORE_ARB_STATS_EN
    ,
    output logic [15:0] grant_cnt
`endif
);
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          cnt <= '0;
        else if (inc && !dec)                cnt <= cnt + 4'd1;
        else if (dec && !inc && cnt != 4'd0) cnt <= cnt - 4'd1;
    end

    assign room = (cnt < 4'(MAX_OUTST));
    assign undf = dec && (cnt == 4'd0);

`ifdef LAB5_MCORE_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   grant_cnt <= '0;
        else if (inc) grant_cnt <= grant_cnt + 16'd1;
    end
`endif
endmodule

module lab5_mcore_mem_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_OUTST = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ*77-1:0]  req_msg,
    input  logic [NREQ-1:0]     req_val,
    output logic [NREQ-1:0]     req_rdy,
    output logic [NREQ*45-1:0]  resp_msg,
    output logic [NREQ-1:0]     resp_val,
    input  logic [NREQ-1:0]     resp_rdy,
    output logic [76:0]         memreq_msg,
    output logic                memreq_val,
    input  logic                memreq_rdy,
    input  logic [44:0]         memresp_msg,
    input  logic                memresp_val,
    output logic                memresp_rdy,
    output logic                err
`ifdef LAB5_MCORE_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]  grant_cnt,
    output logic [31:0]         stall_cnt
`endif
);
    localparam int IDW   = $clog2(NREQ);
    localparam int RQ_LO = 74 - IDW;   // request tag is [73:RQ_LO]
    localparam int RS_LO = 42 - IDW;   // response tag is [41:RS_LO]

    typedef enum logic {ST_IDLE, ST_HOLD} state_t;

    state_t          state, state_nxt;
    logic            hold, hold_load, held_val, scan_found;
    logic            any_elig, req_fire, id_ok, sel_rdy, err_set;
    logic [IDW-1:0]  rr_ptr, hold_id, grant, scan_id, resp_id;
    logic [NREQ-1:0] room, undf, elig, gnt_oh, hold_oh, resp_oh, resp_fire;
    logic [44:0]     resp_clean;

    assign hold     = (state == ST_HOLD);
    assign elig     = req_val & room;
    assign any_elig = |elig;

    // First eligible requester starting at rr_ptr, wrapping mod NREQ.
    always_comb begin
        scan_id    = rr_ptr;
        scan_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!scan_found && elig[(int'(rr_ptr) + k) % NREQ]) begin
                scan_found = 1'b1;
                scan_id    = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    // While holding, the offered requester stays fixed even if it becomes
    // ineligible, so the memory-side message never changes before acceptance.
    assign grant      = hold ? hold_id : scan_id;
    assign memreq_val = reset && (any_elig || hold);
    assign req_fire   = memreq_val && memreq_rdy;

    always_comb begin
        memreq_msg              = req_msg[int'(grant)*77 +: 77];
        memreq_msg[73:RQ_LO]    = grant;
    end

    // Response side: route by the tag, hand every port the untagged message.
    assign resp_id = memresp_msg[41:RS_LO];
    assign id_ok   = (int'(resp_id) < NREQ);

    always_comb begin
        resp_clean             = memresp_msg;
        resp_clean[41:RS_LO]   = '0;
    end

    assign sel_rdy     = |(resp_rdy & resp_oh);
    // Responses with an unknown id are swallowed so memory never stalls on them.
    assign memresp_rdy = reset && (id_ok ? sel_rdy : 1'b1);
    assign held_val    = |(req_val & hold_oh);

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign gnt_oh[i]             = (int'(grant) == i);
        assign hold_oh[i]            = (int'(hold_id) == i);
        assign resp_oh[i]            = id_ok && (int'(resp_id) == i);
        assign req_rdy[i]            = req_fire && gnt_oh[i];
        assign resp_val[i]           = reset && memresp_val && resp_oh[i];
        assign resp_fire[i]          = resp_val[i] && resp_rdy[i];
        assign resp_msg[i*45 +: 45]  = resp_clean;

        lab5_mcore_arb_lane #(.MAX_OUTST(MAX_OUTST)) u_lane (
            .clk       (clk),
            .reset     (reset),
            .inc       (req_rdy[i]),
            .dec       (resp_fire[i]),
            .room      (room[i]),
            .undf      (undf[i])
`ifdef LAB5_MCORE_ARB_STATS_EN
            ,
            .grant_cnt (grant_cnt[i*16 +: 16])
`endif
        );
    end

    // Hold FSM: enter on an offered-but-refused request, leave on acceptance
    // or when the held requester illegally withdraws its valid.
    always_comb begin
        state_nxt = state;
        hold_load = 1'b0;
        case (state)
            ST_IDLE: if (memreq_val && !memreq_rdy) begin
                state_nxt = ST_HOLD;
                hold_load = 1'b1;
            end
            ST_HOLD: if (req_fire || !held_val) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign err_set = (|undf) || (memresp_val && !id_ok) || (hold && !held_val);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            hold_id <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hold_load) hold_id <= grant;
            if (req_fire)  rr_ptr  <= (int'(grant) == NREQ-1) ? '0 : grant + IDW'(1);
            if (err_set)   err     <= 1'b1;
        end
    end

`ifdef LAB5_MCORE_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          stall_cnt <= '0;
        else if (memreq_val && !memreq_rdy)  stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_lab5_mcore_mem_arbiter.sv
// Bench for lab5_mcore_mem_arbiter (NREQ=4, MAX_OUTST=2). A reference model
// tracks outstanding counts, the round-robin pointer and whether an offered
// request is still waiting; every cycle all outputs are compared to it.
module tb_lab5_mcore_mem_arbiter;
    localparam int NREQ = 4;
    localparam int MAXO = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ*77-1:0]  req_msg;
    logic [NREQ-1:0]     req_val, req_rdy, resp_val, resp_rdy;
    logic [NREQ*45-1:0]  resp_msg;
    logic [76:0]         memreq_msg;
    logic                memreq_val, memreq_rdy;
    logic [44:0]         memresp_msg;
    logic                memresp_val, memresp_rdy, err;
`ifdef LAB5_MCORE_ARB_STATS_EN
    logic [NREQ*16-1:0]  grant_cnt;
    logic [31:0]         stall_cnt;
`endif

    lab5_mcore_mem_arbiter #(.NREQ(NREQ), .MAX_OUTST(MAXO)) dut (
        .clk(clk), .reset(reset),
        .req_msg(req_msg), .req_val(req_val), .req_rdy(req_rdy),
        .resp_msg(resp_msg), .resp_val(resp_val), .resp_rdy(resp_rdy),
        .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
        .err(err)
`ifdef LAB5_MCORE_ARB_STATS_EN
        , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int   m_cnt[NREQ];
    int   m_rr;
    bit   m_pend;      // an offered request has not been accepted yet
    int   m_pid;
    bit   m_err;
    // Per-cycle results of eval()
    int   e_g, rs_id;
    bit   e_val, rq_fire, rs_fire;
    logic [76:0] e_msg;
    // Memory stand-in: responses owed, in acceptance order
    logic [44:0] mq[$];
    int   mode;        // 0 silent, 1 return head, 2 random, 3 directed by hand

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [76:0] rand_msg();
        logic [76:0] m;
        m = {13'($urandom), $urandom, $urandom};
        m[73:72] = 2'b00;
        return m;
    endfunction

    // Compare all outputs against the model for the current inputs.
    task automatic eval();
        logic [44:0] r;
        #1;
        if (!reset) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_rr = 0; m_pend = 0; m_err = 0; rq_fire = 0; rs_fire = 0;
            chk("rst_memreq_val", memreq_val, 0);
            chk("rst_req_rdy", req_rdy, 0);
            chk("rst_resp_val", resp_val, 0);
            chk("rst_memresp_rdy", memresp_rdy, 0);
            chk("rst_err", err, 0);
            return;
        end
        e_val = m_pend;
        e_g   = m_pend ? m_pid : 0;
        if (!m_pend) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_rr + k) % NREQ;
                if (!e_val && req_val[i] && m_cnt[i] < MAXO) begin
                    e_val = 1; e_g = i;
                end
            end
        end
        rq_fire = e_val && memreq_rdy;
        chk("memreq_val", memreq_val, e_val);
        chk("req_rdy", req_rdy, rq_fire ? (1 << e_g) : 0);
        e_msg = req_msg[e_g*77 +: 77];
        e_msg[73:72] = 2'(e_g);
        if (e_val) chk("memreq_msg", memreq_msg, e_msg);
        rs_id = int'(memresp_msg[41:40]);
        rs_fire = memresp_val && resp_rdy[rs_id];
        chk("memresp_rdy", memresp_rdy, resp_rdy[rs_id]);
        chk("resp_val", resp_val, memresp_val ? (1 << rs_id) : 0);
        r = memresp_msg;
        r[41:40] = 2'b00;
        chk("resp_msg", resp_msg, {NREQ{r}});
        chk("err", err, m_err);
    endtask

    // Advance one clock: update the model, then drive the next memory response.
    task automatic tick();
        bit viol;
        @(posedge clk);
        if (!reset) begin
            mq.delete();
        end else begin
            viol = m_pend && !req_val[m_pid];
            if (rs_fire) begin
                if (m_cnt[rs_id] == 0) m_err = 1;
                for (int j = 0; j < mq.size(); j++)
                    if (int'(mq[j][41:40]) == rs_id) begin mq.delete(j); break; end
            end
            if (viol) m_err = 1;
            if (rq_fire) begin
                m_cnt[e_g]++;
                m_rr = (e_g + 1) % NREQ;
                m_pend = 0;
                mq.push_back({3'b000, e_msg[73:66], 2'b00, $urandom});
            end else if (viol) begin
                m_pend = 0;
            end else if (e_val) begin
                m_pend = 1; m_pid = e_g;
            end
            if (rs_fire && m_cnt[rs_id] > 0) m_cnt[rs_id]--;
        end
        @(negedge clk);
        if (mode == 2) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_val[i] || (rq_fire && e_g == i)) begin
                    req_val[i] = 1'($urandom_range(0, 1));
                    req_msg[i*77 +: 77] = rand_msg();
                end
            end
            memreq_rdy = ($urandom_range(0, 3) != 0);
            resp_rdy   = 4'($urandom);
        end
        if (mode == 0) memresp_val = 1'b0;
        if (mode == 1 || mode == 2) begin
            memresp_val = (mq.size() > 0) && (mode == 1 || $urandom_range(0, 1) == 1);
            memresp_msg = (mq.size() > 0) ? mq[0] : '0;
        end
    endtask

    initial begin
        logic [76:0] exp1;
        int n1;
        reset = 1'b0; mode = 0;
        req_val = '1; memreq_rdy = 1'b1; resp_rdy = '1;
        memresp_val = 1'b0; memresp_msg = '0;
        for (int i = 0; i < NREQ; i++) req_msg[i*77 +: 77] = rand_msg();
        @(negedge clk);
        eval(); tick();
        reset = 1'b1; req_val = '0;
        eval(); tick();

        // Round robin with responses returned the following cycle
        mode = 1; req_val = '1; memreq_rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            eval(); chk("rr_tag", memreq_msg[73:72], c % 4); tick();
        end
        req_val = '0;
        repeat (3) begin eval(); tick(); end

        // Grant hold on requester 1 while memory stalls
        req_val = 4'b0110; memreq_rdy = 1'b0;
        exp1 = req_msg[77 +: 77]; exp1[73:72] = 2'd1;
        for (int c = 0; c < 3; c++) begin
            eval(); chk("hold_msg", memreq_msg, exp1); chk("hold_rdy", req_rdy, 0); tick();
        end
        memreq_rdy = 1'b1;
        eval(); chk("hold_msg_fire", memreq_msg, exp1); chk("hold_fire_rdy", req_rdy, 4'b0010); tick();
        req_val = 4'b0100;
        eval(); chk("hold_next_grant", memreq_msg[73:72], 2); tick();
        req_val = '0;
        repeat (4) begin eval(); tick(); end

        // Outstanding limit on requester 0
        mode = 0; req_val = 4'b0001;
        eval(); chk("lim_fire1", req_rdy, 4'b0001); tick();
        eval(); chk("lim_fire2", req_rdy, 4'b0001); tick();
        eval(); chk("lim_block", req_rdy, 0); chk("lim_noval", memreq_val, 0); tick();
        memresp_val = 1'b1; memresp_msg = mq[0];
        eval(); chk("lim_resp", resp_val, 4'b0001); chk("lim_still_block", req_rdy, 0); tick();
        eval(); chk("lim_reopen", req_rdy, 4'b0001); tick();
        req_val = '0; mode = 1;
        repeat (4) begin eval(); tick(); end

        // Response routing to requester 3 with backpressure
        mode = 0; req_val = 4'b1000;
        eval(); chk("route_setup", req_rdy, 4'b1000); tick();
        req_val = '0; mode = 3;
        memresp_val = 1'b1; memresp_msg = {3'b000, 2'd3, 6'h05, 2'b00, 32'hdeadbeef};
        resp_rdy = 4'b0111;
        for (int c = 0; c < 2; c++) begin
            eval(); chk("route_stall_rdy", memresp_rdy, 0); chk("route_val", resp_val, 4'b1000); tick();
        end
        resp_rdy = '1; req_val = 4'b1000;
        eval();
        chk("route_rdy", memresp_rdy, 1);
        chk("route_data", resp_msg[3*45 +: 32], 32'hdeadbeef);
        chk("route_tag", resp_msg[3*45+40 +: 2], 0);
        chk("route_req_fire", req_rdy, 4'b1000);
        tick();
        memresp_val = 1'b0;
        eval(); chk("cnt3_same_fire", req_rdy, 4'b1000); tick();
        eval(); chk("cnt3_full", req_rdy, 0); tick();
        req_val = '0; mode = 1;
        repeat (5) begin eval(); tick(); end

        // Response to a requester with nothing outstanding
        mode = 3; memresp_val = 1'b1;
        memresp_msg = {3'b000, 2'd2, 6'h00, 2'b00, 32'h00001234};
        eval(); chk("err_consume", memresp_rdy, 1); chk("err_before", err, 0); tick();
        memresp_val = 1'b0;
        eval(); chk("err_set", err, 1); tick();

        // Reset in the middle of a hold
        mode = 0; req_val = 4'b0010; memreq_rdy = 1'b0;
        eval(); tick();
        eval(); chk("in_hold", memreq_val, 1); tick();
        reset = 1'b0;
        eval(); chk("midrst_val", memreq_val, 0); chk("midrst_err", err, 0); tick();
        reset = 1'b1; req_val = '1; memreq_rdy = 1'b1;
        eval(); chk("post_rst_grant", memreq_msg[73:72], 0); tick();

        // Five stall cycles, then three fires from requester 1
        mode = 1; req_val = 4'b0010; memreq_rdy = 1'b0;
        repeat (5) begin eval(); tick(); end
        memreq_rdy = 1'b1; n1 = 0;
        for (int c = 0; c < 20 && n1 < 3; c++) begin
            eval(); if (rq_fire && e_g == 1) n1++; tick();
        end
        chk("stats_fires_seen", n1, 3);
        req_val = '0;
        eval();
`ifdef LAB5_MCORE_ARB_STATS_EN
        chk("stall_cnt", stall_cnt, 5);
        chk("grant_cnt1", grant_cnt[16 +: 16], 3);
        chk("grant_cnt0", grant_cnt[0 +: 16], 1);
`endif
        tick();

        // Randomized traffic against the model
        mode = 2;
        repeat (400) begin eval(); tick(); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
